// File: rtl/alu_mc_if.sv
// Handshake bundle for alu_mc: operand/op issue side (IN_*) and result side (OUT_*, F, FH, flags).
// The issuing stage uses the master modport and the ALU uses the slave modport.
interface alu_mc_if #(
   parameter int WIDTH = 32
);
   logic             IN_VALID;
   logic             IN_READY;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       ALU_OP;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [WIDTH-1:0] F;
   logic [WIDTH-1:0] FH;
   logic             ZF;
   logic             OF;
   logic             CF;
   logic             DZ;

   modport master (
      output IN_VALID, A, B, ALU_OP, OUT_READY,
      input  IN_READY, OUT_VALID, F, FH, ZF, OF, CF, DZ
   );

   modport slave (
      input  IN_VALID, A, B, ALU_OP, OUT_READY,
      output IN_READY, OUT_VALID, F, FH, ZF, OF, CF, DZ
   );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: logic/arith/shift/compare in 1 cycle, MULU/DIVU iterate one bit per cycle (WIDTH cycles).
// Results are registered and held while OUT_VALID && !OUT_READY; IN_READY drops until the result is taken.
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic   CLK,
   input logic   RST,
   alu_mc_if.slave bus
);

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_NOR  = 4'd3;
   localparam logic [3:0] OP_ADD  = 4'd4;
   localparam logic [3:0] OP_SUB  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;
   localparam logic [3:0] OP_SLTU = 4'd10;
   localparam logic [3:0] OP_MULU = 4'd11;
   localparam logic [3:0] OP_DIVU = 4'd12;

   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] f;
      logic [WIDTH-1:0] fh;
      logic             zf;
      logic             of;
      logic             cf;
      logic             dz;
   } res_t;

   state_t           state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic             is_div_q, is_div_d;
   res_t             res_q, res_d;

   res_t             alu_res, iter_res;
   logic             in_ready, out_valid, accept, multi;
   logic [SHW-1:0]   amt;
   logic [WIDTH:0]   add_sum, sub_diff;
   logic [WIDTH:0]   mul_sum, div_trial, div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] iter_hi, iter_lo;

   assign accept = bus.IN_VALID && in_ready;
   assign multi  = (bus.ALU_OP == OP_MULU) || ((bus.ALU_OP == OP_DIVU) && (bus.B != '0));
   assign amt    = bus.A[SHW-1:0];

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = multi ? S_BUSY : S_DONE;
         S_BUSY: if (cnt_q == CNT_LAST) state_d = S_DONE;
         S_DONE: begin
            if (accept)             state_d = multi ? S_BUSY : S_DONE;
            else if (bus.OUT_READY) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready      = !RST && ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.OUT_READY));
      out_valid     = (state_q == S_DONE);
      bus.IN_READY  = in_ready;
      bus.OUT_VALID = out_valid;
      bus.F         = res_q.f;
      bus.FH        = res_q.fh;
      bus.ZF        = res_q.zf;
      bus.OF        = res_q.of;
      bus.CF        = res_q.cf;
      bus.DZ        = res_q.dz;
   end

   // Single-cycle result; DIVU only lands here when B is zero
   always_comb begin
      alu_res  = '0;
      add_sum  = {1'b0, bus.A} + {1'b0, bus.B};
      sub_diff = {1'b0, bus.A} - {1'b0, bus.B};
      case (bus.ALU_OP)
         OP_AND:  alu_res.f = bus.A & bus.B;
         OP_OR:   alu_res.f = bus.A | bus.B;
         OP_XOR:  alu_res.f = bus.A ^ bus.B;
         OP_NOR:  alu_res.f = ~(bus.A | bus.B);
         OP_ADD: begin
            alu_res.f  = add_sum[WIDTH-1:0];
            alu_res.cf = add_sum[WIDTH];
            alu_res.of = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (add_sum[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res.f  = sub_diff[WIDTH-1:0];
            alu_res.cf = sub_diff[WIDTH];
            alu_res.of = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sub_diff[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SLT:  alu_res.f = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
         OP_SLL:  alu_res.f = bus.B << amt;
         OP_SRL:  alu_res.f = bus.B >> amt;
         OP_SRA:  alu_res.f = $signed(bus.B) >>> amt;
         OP_SLTU: alu_res.f = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
         OP_DIVU: begin
            alu_res.f  = '1;
            alu_res.fh = bus.A;
            alu_res.dz = 1'b1;
         end
         default: alu_res = '0;
      endcase
      alu_res.zf = (alu_res.f == '0);
   end

   // One iteration: shift-add multiply (hi:lo shifts right) or restoring divide (hi:lo shifts left)
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_trial = {hi_q, lo_q[WIDTH-1]};
      div_diff  = div_trial - {1'b0, opnd_q};
      div_ge    = (div_trial >= {1'b0, opnd_q});
      if (is_div_q) begin
         iter_hi = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
         iter_lo = {lo_q[WIDTH-2:0], div_ge};
      end else begin
         iter_hi = mul_sum[WIDTH:1];
         iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
      iter_res    = '0;
      iter_res.f  = iter_lo;
      iter_res.fh = iter_hi;
      iter_res.zf = (iter_lo == '0);
   end

   always_comb begin
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      res_d    = res_q;
      if (accept) begin
         if (multi) begin
            cnt_d    = '0;
            hi_d     = '0;
            is_div_d = (bus.ALU_OP == OP_DIVU);
            lo_d     = is_div_d ? bus.A : bus.B;
            opnd_d   = is_div_d ? bus.B : bus.A;
         end else begin
            res_d = alu_res;
         end
      end else if (state_q == S_BUSY) begin
         cnt_d = cnt_q + 1'b1;
         hi_d  = iter_hi;
         lo_d  = iter_lo;
         if (cnt_q == CNT_LAST) res_d = iter_res;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         res_q    <= '0;
      end else begin
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
         res_q    <= res_d;
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=32): directed corner cases, random ops against an arithmetic model,
// backpressure/streaming and reset during a multiply.
module tb_alu_mc;

   typedef struct packed {
      logic [31:0] f;
      logic [31:0] fh;
      logic        zf;
      logic        of;
      logic        cf;
      logic        dz;
   } res_t;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic CLK = 1'b0;
   logic RST;
   int   errors = 0;
   int   checks = 0;

   alu_mc_if #(.WIDTH(32)) bus ();

   alu_mc #(.WIDTH(32)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      res_t              r;
      longint            sa, sb, s;
      longint unsigned   ua, ub, p;
      r  = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         4'd0:  r.f = a & b;
         4'd1:  r.f = a | b;
         4'd2:  r.f = a ^ b;
         4'd3:  r.f = ~(a | b);
         4'd4: begin
            r.f  = a + b;
            r.cf = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
            s    = sa + sb;
            r.of = (s > SMAX) || (s < SMIN);
         end
         4'd5: begin
            r.f  = a - b;
            r.cf = ua < ub;
            s    = sa - sb;
            r.of = (s > SMAX) || (s < SMIN);
         end
         4'd6:  r.f = {31'd0, sa < sb};
         4'd7:  r.f = b << a[4:0];
         4'd8:  r.f = b >> a[4:0];
         4'd9:  r.f = $signed(b) >>> a[4:0];
         4'd10: r.f = {31'd0, ua < ub};
         4'd11: begin
            p    = ua * ub;
            r.f  = p[31:0];
            r.fh = p[63:32];
         end
         4'd12: begin
            if (b == 32'd0) begin
               r.f  = 32'hFFFF_FFFF;
               r.fh = a;
               r.dz = 1'b1;
            end else begin
               r.f  = a / b;
               r.fh = a % b;
            end
         end
         default: r = '0;
      endcase
      r.zf = (r.f == 32'd0);
      return r;
   endfunction

   // Issue one op with OUT_READY low, wait for the result, then consume it.
   // lat counts sampled edges including the accept edge: 1 for single-cycle ops, 33 for MULU/DIVU.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output res_t obs, output int lat, output bit ir_low);
      int guard = 0;
      while (!bus.IN_READY && guard < 200) begin
         @(posedge CLK); #1;
         guard++;
      end
      if (guard >= 200) begin
         checks++; errors++;
         $display("FAIL run_op_ready_timeout: IN_READY=%b required 1", bus.IN_READY);
      end
      bus.OUT_READY = 1'b0;
      bus.IN_VALID  = 1'b1;
      bus.ALU_OP    = op;
      bus.A         = a;
      bus.B         = b;
      lat    = 0;
      ir_low = 1'b1;
      do begin
         @(posedge CLK); #1;
         bus.IN_VALID = 1'b0;
         bus.A        = $urandom;
         bus.B        = $urandom;
         lat++;
         if (bus.IN_READY) ir_low = 1'b0;
      end while (!bus.OUT_VALID && lat < 200);
      if (lat >= 200) begin
         checks++; errors++;
         $display("FAIL run_op_result_timeout: OUT_VALID=%b required 1", bus.OUT_VALID);
      end
      obs = {bus.F, bus.FH, bus.ZF, bus.OF, bus.CF, bus.DZ};
      bus.OUT_READY = 1'b1;
      @(posedge CLK); #1;
      bus.OUT_READY = 1'b0;
   endtask

   task automatic test_reset;
      RST = 1'b1;
      bus.IN_VALID = 1'b1;
      bus.ALU_OP = 4'd4; bus.A = 32'h1; bus.B = 32'h2;
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if (bus.OUT_VALID !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b required 0", bus.OUT_VALID);
      end
      checks++;
      if ({bus.F, bus.FH} !== 64'd0) begin
         errors++; $display("FAIL reset_results: got %h required 0", {bus.F, bus.FH});
      end
      checks++;
      if ({bus.ZF, bus.OF, bus.CF, bus.DZ} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags: got %b required 0000", {bus.ZF, bus.OF, bus.CF, bus.DZ});
      end
      checks++;
      if (bus.IN_READY !== 1'b0) begin
         errors++; $display("FAIL reset_in_ready_low: got %b required 0", bus.IN_READY);
      end
      bus.IN_VALID = 1'b0;
      RST = 1'b0;
      #1;
      checks++;
      if (bus.IN_READY !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready_after: got %b required 1", bus.IN_READY);
      end
   endtask

   task automatic test_single_cycle;
      logic [3:0]  ops [13] = '{4'd4, 4'd4, 4'd5, 4'd6, 4'd10, 4'd9, 4'd7, 4'd8, 4'd0, 4'd1, 4'd3, 4'd13, 4'd15};
      logic [31:0] as  [13] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd36,
                                32'd4, 32'd8, 32'h0000_F0F0, 32'h0000_F0F0, 32'd0, 32'd5, 32'hDEAD_BEEF};
      logic [31:0] bs  [13] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'h8000_0000,
                                32'h0000_00F1, 32'hF000_0000, 32'h0000_FF00, 32'h0000_FF00, 32'd0, 32'd5, 32'h1234_5678};
      logic [31:0] fs  [13] = '{32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hF800_0000,
                                32'h0000_0F10, 32'h00F0_0000, 32'h0000_F000, 32'h0000_FFF0, 32'hFFFF_FFFF, 32'd0, 32'd0};
      res_t obs, exp;
      int   lat;
      bit   irl;
      for (int i = 0; i < 13; i++) begin
         run_op(ops[i], as[i], bs[i], obs, lat, irl);
         exp = model(ops[i], as[i], bs[i]);
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL single_model op=%0d: got %h required %h", ops[i], obs, exp);
         end
         checks++;
         if (obs.f !== fs[i]) begin
            errors++; $display("FAIL single_const op=%0d: F=%h required %h", ops[i], obs.f, fs[i]);
         end
         checks++;
         if (lat !== 1) begin
            errors++; $display("FAIL single_latency op=%0d: got %0d required 1", ops[i], lat);
         end
      end
   endtask

   task automatic test_mulu;
      res_t obs;
      int   lat;
      bit   irl;
      run_op(4'd11, 32'hFFFF_FFFF, 32'd2, obs, lat, irl);
      checks++;
      if ({obs.fh, obs.f} !== 64'h0000_0001_FFFF_FFFE) begin
         errors++; $display("FAIL mulu_product: got %h required 00000001fffffffe", {obs.fh, obs.f});
      end
      checks++;
      if ({obs.zf, obs.of, obs.cf, obs.dz} !== 4'b0000) begin
         errors++; $display("FAIL mulu_flags: got %b required 0000", {obs.zf, obs.of, obs.cf, obs.dz});
      end
      checks++;
      if (lat !== 33) begin
         errors++; $display("FAIL mulu_latency: got %0d edges after accept required 32", lat - 1);
      end
      checks++;
      if (irl !== 1'b1) begin
         errors++; $display("FAIL mulu_in_ready_low: got %b required 1", irl);
      end
   endtask

   task automatic test_divu;
      res_t obs;
      int   lat;
      bit   irl;
      run_op(4'd12, 32'd100, 32'd7, obs, lat, irl);
      checks++;
      if ({obs.f, obs.fh, obs.dz} !== {32'd14, 32'd2, 1'b0}) begin
         errors++; $display("FAIL divu_100_7: got F=%0d FH=%0d DZ=%b required 14 2 0", obs.f, obs.fh, obs.dz);
      end
      checks++;
      if (lat !== 33 || irl !== 1'b1) begin
         errors++; $display("FAIL divu_latency: got %0d edges (ready_low=%b) required 32 (1)", lat - 1, irl);
      end
      run_op(4'd12, 32'h1234, 32'd0, obs, lat, irl);
      checks++;
      if ({obs.f, obs.fh, obs.dz, obs.zf} !== {32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0}) begin
         errors++; $display("FAIL divu_by_zero: got F=%h FH=%h DZ=%b ZF=%b required ffffffff 1234 1 0",
                            obs.f, obs.fh, obs.dz, obs.zf);
      end
      checks++;
      if (lat !== 1) begin
         errors++; $display("FAIL divu_by_zero_latency: got %0d required 1", lat);
      end
   endtask

   task automatic test_random;
      res_t        obs, exp;
      int          lat, exp_lat;
      bit          irl;
      logic [3:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 150; i++) begin
         op = 4'($urandom_range(0, 15));
         if (i % 5 == 0) op = 4'($urandom_range(11, 12));
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1000));
         run_op(op, a, b, obs, lat, irl);
         exp     = model(op, a, b);
         exp_lat = (op == 4'd11 || (op == 4'd12 && b != 32'd0)) ? 33 : 1;
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL random_result op=%0d a=%h b=%h: got %h required %h", op, a, b, obs, exp);
         end
         checks++;
         if (lat !== exp_lat) begin
            errors++; $display("FAIL random_latency op=%0d: got %0d required %0d", op, lat, exp_lat);
         end
      end
   endtask

   task automatic test_back_to_back;
      res_t        snap, cur, exp;
      logic [31:0] xa [4];
      logic [31:0] xb [4];
      bus.OUT_READY = 1'b0;
      bus.IN_VALID  = 1'b1;
      bus.ALU_OP    = 4'd4;
      bus.A         = 32'h8000_0001;
      bus.B         = 32'h8000_0002;
      @(posedge CLK); #1;
      bus.IN_VALID = 1'b0;
      bus.A = $urandom; bus.B = $urandom;
      snap = {bus.F, bus.FH, bus.ZF, bus.OF, bus.CF, bus.DZ};
      exp  = model(4'd4, 32'h8000_0001, 32'h8000_0002);
      checks++;
      if (snap !== exp || bus.OUT_VALID !== 1'b1) begin
         errors++; $display("FAIL bp_first_result: got %h valid=%b required %h valid=1", snap, bus.OUT_VALID, exp);
      end
      for (int c = 0; c < 5; c++) begin
         bus.IN_VALID = 1'b1;
         @(posedge CLK); #1;
         cur = {bus.F, bus.FH, bus.ZF, bus.OF, bus.CF, bus.DZ};
         checks++;
         if (cur !== snap || bus.IN_READY !== 1'b0 || bus.OUT_VALID !== 1'b1) begin
            errors++; $display("FAIL bp_hold cycle %0d: got %h ready=%b valid=%b required %h ready=0 valid=1",
                               c, cur, bus.IN_READY, bus.OUT_VALID, snap);
         end
      end
      bus.OUT_READY = 1'b1;
      bus.ALU_OP    = 4'd2;
      for (int i = 0; i < 4; i++) begin
         xa[i] = $urandom;
         xb[i] = $urandom;
         bus.IN_VALID = 1'b1;
         bus.A = xa[i];
         bus.B = xb[i];
         @(posedge CLK); #1;
         checks++;
         if (bus.OUT_VALID !== 1'b1 || bus.F !== (xa[i] ^ xb[i])) begin
            errors++; $display("FAIL stream_xor %0d: valid=%b F=%h required valid=1 F=%h",
                               i, bus.OUT_VALID, bus.F, xa[i] ^ xb[i]);
         end
      end
      bus.IN_VALID = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (bus.OUT_VALID !== 1'b0) begin
         errors++; $display("FAIL stream_drain: OUT_VALID=%b required 0", bus.OUT_VALID);
      end
      bus.OUT_READY = 1'b0;
   endtask

   task automatic test_reset_mid_op;
      bit saw_valid = 1'b0;
      bus.OUT_READY = 1'b0;
      bus.IN_VALID  = 1'b1;
      bus.ALU_OP    = 4'd11;
      bus.A         = $urandom | 32'h1;
      bus.B         = $urandom | 32'h1;
      @(posedge CLK); #1;
      bus.IN_VALID = 1'b0;
      repeat (9) begin
         @(posedge CLK); #1;
      end
      checks++;
      if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b0) begin
         errors++; $display("FAIL mid_busy: valid=%b ready=%b required 0 0", bus.OUT_VALID, bus.IN_READY);
      end
      RST = 1'b1;
      @(posedge CLK); #1;
      checks++;
      if ({bus.OUT_VALID, bus.IN_READY, bus.F, bus.FH, bus.ZF, bus.OF, bus.CF, bus.DZ} !== 70'd0) begin
         errors++; $display("FAIL mid_reset_outputs: valid=%b ready=%b F=%h FH=%h flags=%b required all 0",
                            bus.OUT_VALID, bus.IN_READY, bus.F, bus.FH, {bus.ZF, bus.OF, bus.CF, bus.DZ});
      end
      RST = 1'b0;
      #1;
      checks++;
      if (bus.IN_READY !== 1'b1) begin
         errors++; $display("FAIL mid_reset_ready: got %b required 1", bus.IN_READY);
      end
      repeat (40) begin
         @(posedge CLK); #1;
         if (bus.OUT_VALID) saw_valid = 1'b1;
      end
      checks++;
      if (saw_valid !== 1'b0) begin
         errors++; $display("FAIL mid_reset_stale: stale OUT_VALID seen=%b required 0", saw_valid);
      end
   endtask

   initial begin
      RST           = 1'b1;
      bus.IN_VALID  = 1'b0;
      bus.OUT_READY = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      bus.ALU_OP    = '0;
      test_reset();
      test_single_cycle();
      test_mulu();
      test_divu();
      test_random();
      test_back_to_back();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, multi-cycle successor to the datapath's single-cycle ALU. It adds a valid/ready handshake on both sides, registered results, and a full flag set (ZF, OF, CF, DZ). It extends the op set with right shifts, unsigned compare, and iterative unsigned multiply and divide. It sits between the decode/register-read stage and writeback, and it stalls the issuing stage through `IN_READY`.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; power of two, ≥ 8.
- `SHW`, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports (reset RST, synchronous, active-high):
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `IN_VALID`  in  1  `A`, `B` and `ALU_OP` are valid.
- `IN_READY`  out  1  block accepts an operation this cycle.
- `A`  in  WIDTH  operand A; `A[SHW-1:0]` is the shift amount for shifts.
- `B`  in  WIDTH  operand B; the shifted value for shifts.
- `ALU_OP`  in  4  operation code.
- `OUT_VALID`  out  1  result registers hold a new result.
- `OUT_READY`  in  1  consumer takes the result this cycle.
- `F`  out  WIDTH  primary result.
- `FH`  out  WIDTH  high product (MULU) or remainder (DIVU); 0 for all other ops.
- `ZF`  out  1  F == 0.
- `OF`  out  1  signed overflow (ADD/SUB only).
- `CF`  out  1  carry out (ADD) or borrow (SUB).
- `DZ`  out  1  divide by zero (DIVU only).

## Operation
- ALU_OP encoding and results:
  - 0 AND: `F = A & B`.
  - 1 OR: `F = A | B`.
  - 2 XOR: `F = A ^ B`.
  - 3 NOR: `F = ~(A | B)`.
  - 4 ADD: `F = A + B` mod 2^WIDTH.
  - 5 SUB: `F = A − B` mod 2^WIDTH.
  - 6 SLT (signed): F is 1 if A < B signed, else 0.
  - 7 SLL: `F = B << A[SHW-1:0]`.
  - 8 SRL: logical right shift of B by `A[SHW-1:0]`.
  - 9 SRA: arithmetic right shift of B by `A[SHW-1:0]`.
  - 10 SLTU: F is 1 if A < B unsigned, else 0.
  - 11 MULU: `{FH,F} = A × B`, unsigned, full 2·WIDTH product.
  - 12 DIVU: `F = A / B`, `FH = A % B`, unsigned.
  - 13–15: `F = 0`, all flags 0.
- Shift-amount bits above `SHW-1` are ignored.
- Flags:
  - OF for ADD = `A[msb]==B[msb] && F[msb]!=A[msb]`.
  - OF for SUB = `A[msb]!=B[msb] && F[msb]!=A[msb]`.
  - CF for ADD = bit WIDTH of `A+B`; CF for SUB = 1 when A < B unsigned.
  - OF and CF are 0 for all other ops. ZF is computed on F for every op.
- DIVU with B = 0: `F` = all ones, `FH = A`, `DZ = 1`, single-cycle path. DZ is 0 for every other case.
- State machine:
  - IDLE: `IN_READY = 1`.
  - BUSY: iterative MULU (shift-add) or DIVU (restoring), one bit per cycle, with a counter running 0..WIDTH−1.
  - DONE: `OUT_VALID = 1`.
- Transitions:
  - IDLE → DONE on accept of a single-cycle op, including DIVU with B = 0.
  - IDLE → BUSY on accept of MULU, or DIVU with B ≠ 0.
  - BUSY → DONE when the counter reaches WIDTH−1.
  - DONE → IDLE on `OUT_READY` with no new accept.
  - DONE → DONE or BUSY on `OUT_READY` together with a new accept.
- `IN_READY = !RST && (state==IDLE || (state==DONE && OUT_READY))`.
- Accept = `IN_VALID && IN_READY`. Operands are captured at accept; later input changes are ignored.

## Timing
- Reset: at a rising edge with RST high, the state goes to IDLE and the counter clears. `F`, `FH`, `ZF`, `OF`, `CF`, `DZ` and `OUT_VALID` go to 0. `IN_READY` is 0 while RST is high.
- Reset mid-operation (BUSY or DONE) aborts the operation. The result is discarded and no `OUT_VALID` is produced for it.
- Single-cycle ops: accepted at edge k, so `OUT_VALID` and results are visible after edge k. Latency is 1, and throughput is 1 per cycle while `OUT_READY` stays high.
- MULU/DIVU: accepted at edge k, so `OUT_VALID` rises after edge k+WIDTH. `IN_READY` is 0 from accept until DONE.
- Backpressure: while `OUT_VALID && !OUT_READY`, all result outputs are held stable and `IN_READY` is 0.
- Simultaneous `OUT_READY` and new accept in DONE: the old result is consumed, and the new one replaces it at the same edge. For a single-cycle op, `OUT_VALID` stays high with no bubble.
- `OUT_VALID` falls after an edge with `OUT_READY` high and no new accept.

## Test plan
- ADD `0x7FFFFFFF + 0x1` → `F = 0x80000000`, `OF = 1`, `CF = 0`, `ZF = 0`, `OUT_VALID` 1 cycle after accept. ADD `0xFFFFFFFF + 1` → `F = 0`, `ZF = 1`, `CF = 1`, `OF = 0`.
- SUB `0 − 1` → `F = 0xFFFFFFFF`, `CF = 1`, `OF = 0`. SLT `A = 0xFFFFFFFF`, `B = 1` → 1. SLTU with the same operands → 0. SRA `B = 0x80000000`, `A = 36` → `0xF8000000`.
- MULU `0xFFFFFFFF × 2` → `F = 0xFFFFFFFE`, `FH = 1`. `OUT_VALID` rises exactly 32 edges after accept, and `IN_READY` is 0 throughout.
- DIVU `100 / 7` → `F = 14`, `FH = 2`, `DZ = 0` after 32 cycles. DIVU `0x1234 / 0` → `F = 0xFFFFFFFF`, `FH = 0x1234`, `DZ = 1` after 1 cycle.
- Backpressure and streaming:
  - Hold `OUT_READY` low for 5 cycles: outputs stay stable and `IN_READY` stays 0.
  - Then raise `OUT_READY` and issue 4 back-to-back XORs: 4 results arrive on 4 consecutive cycles.
- RST asserted 10 cycles into a MULU → after that edge, `OUT_VALID = 0` and all outputs are 0. After RST drops, `IN_READY = 1`, and no stale result ever appears.
